led_stretch_bank: RTL and testbench
===================================

Name: led_stretch_bank

Overview:
Multi-channel LED pulse stretcher for front-panel indicators. Each channel turns a short synchronous event into a visible LED-on time, in one of four per-channel modes: off, retriggerable stretch, sticky latch, or blinking stretch. A shared lamp-test sequence lights all LEDs after reset. Outputs are active-high; the open-drain inversion is done at the top level.

Parameters:
CHANNELS, 8, number of independent LED channels (1..32)
TIMER_BITS, 15, width of each per-channel hold counter
HOLD, 2**TIMER_BITS-1, cycles q stays high after the last trigger; range 1..2**TIMER_BITS-1
BLINK_BITS, 12, width of the shared blink prescaler; blink period is 2**BLINK_BITS cycles
LAMP_TEST, 1, 1 = all q held high for HOLD cycles after reset release; 0 = no lamp test

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-low
d  in  CHANNELS  trigger per channel, active high, synchronous to clk
mode  in  2*CHANNELS  per-channel mode; channel i uses mode[2i+1:2i]; quasi-static
clr  in  CHANNELS  per-channel clear for LATCH mode, active high
q  out  CHANNELS  registered LED-on outputs, active high

Behaviour:
- Modes (led_pkg::led_mode_t): OFF=0, STRETCH=1, LATCH=2, BLINK=3.
- Reset (nrst low at an edge):
  - All hold counters are 0 and all latch bits are 0.
  - The blink prescaler is 0.
  - q is all ones.
  - The lamp counter loads HOLD if LAMP_TEST=1, otherwise 0.
- Lamp test:
  - While the lamp counter is non-zero, q is all ones regardless of mode, and the counter decrements once per cycle.
  - For the first HOLD cycles after reset release q stays high; q follows channel logic from edge HOLD onward.
  - Channel state keeps updating during lamp test, so a trigger during lamp test is not lost.
- Hold counter (STRETCH and BLINK modes):
  - d high loads HOLD.
  - Otherwise the counter decrements while non-zero and saturates at 0; it never wraps.
  - Retrigger reloads HOLD.
- Channel "active" is next-counter-value != 0, computed from the same-edge update.
  - q rises on the edge where d is sampled (1-cycle latency).
  - A single-cycle d at edge k gives q high after edges k..k+HOLD-1 and low after edge k+HOLD: exactly HOLD cycles.
- STRETCH: q = active.
- BLINK: q = active AND NOT prescaler MSB.
  - The prescaler runs freely from reset, shared by all channels; the phase is not aligned to the trigger.
- LATCH:
  - The latch bit sets on d and clears on clr.
  - If d and clr are high in the same cycle, d wins (the bit stays set).
  - q = latch bit.
  - The hold counter is still maintained.
- OFF:
  - q = 0.
  - The hold counter and latch bit are forced to 0 at each edge.
  - d and clr are ignored.
- Mode change:
  - Takes effect at the next edge.
  - Counter and latch state carry over, except that OFF clears them. Example: STRETCH->LATCH mid-hold shows the latch bit, not the remaining hold.
- clr has no effect outside LATCH mode.
- Width rules:
  - Counters are unsigned TIMER_BITS wide; the decrement uses a TIMER_BITS-wide constant 1.
  - HOLD is truncated to TIMER_BITS; elaboration fails via assertion if HOLD==0 or HOLD>=2**TIMER_BITS.
- Reset mid-operation: all state returns to reset values at that edge and the lamp test restarts.

Decomposition:
- led_pkg holds:
  - the led_mode_t enum (2 bits);
  - LED_MODE_W=2;
  - a function extracting channel i's mode from the packed mode bus.
- Sub-module led_stretch_chan (one channel) contains:
  - the hold counter and latch bit;
  - mode decode;
  - inputs: d, clr, mode, blink_phase, lamp_active;
  - output: q_next, registered in the parent or in the channel.
- The parent owns the blink prescaler, the lamp counter, and the generate loop over CHANNELS.

Test Plan:
1. Lamp test (CHANNELS=4, HOLD=4, LAMP_TEST=1): hold nrst low 3 cycles, then release, all modes STRETCH, d=0 -> q=4'hF during reset and for 4 cycles after release, then 4'h0.
2. STRETCH retrigger (HOLD=4, lamp test done): d[0] pulses at edge 10 and edge 12 -> q[0] high from edge 10 through edge 15, low after edge 16; other channels stay 0.
3. LATCH priority: mode[1]=LATCH; d[1] at edge 20; clr[1] and d[1] together at edge 25; clr[1] alone at edge 30 -> q[1] high from edge 20 through edge 29, low from edge 30.
4. BLINK (BLINK_BITS=3, HOLD=20): d[2] single pulse -> q[2] toggles with period 8 (4 on, 4 off, aligned to the prescaler MSB) and is 0 after the hold expires.
5. OFF override: channel 3 in STRETCH mid-hold, switch mode to OFF, then back to STRETCH with no d -> q[3]=0 the edge after OFF, and it stays 0 after returning to STRETCH.
6. Reset mid-hold (LAMP_TEST=0): channel 0 active, nrst pulsed low 1 cycle -> q all ones during reset, 0 the edge after release, counters cleared.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types for the LED stretcher bank: channel mode encoding and a helper
// that pulls one channel's mode field out of the packed mode bus.
package led_pkg;

  localparam int LED_MODE_W   = 2;
  localparam int MAX_CHANNELS = 32;
  localparam int MODE_BUS_W   = LED_MODE_W * MAX_CHANNELS;

  typedef enum logic [LED_MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_STRETCH = 2'd1,
    MODE_LATCH   = 2'd2,
    MODE_BLINK   = 2'd3
  } led_mode_t;

  // The bus is passed zero-extended to the maximum channel count.
  function automatic led_mode_t chan_mode(input logic [MODE_BUS_W-1:0] bus,
                                          input int unsigned idx);
    return led_mode_t'(bus[LED_MODE_W*idx +: LED_MODE_W]);
  endfunction

endpackage

// File: rtl/led_stretch_chan.sv
// One LED channel: hold counter, latch bit and mode decode. Produces the
// next-cycle LED value; the parent registers it.
module led_stretch_chan
  import led_pkg::*;
#(
  parameter int                    TIMER_BITS = 15,
  parameter logic [TIMER_BITS-1:0] HOLD_V     = '1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  d,
  input  logic                  clr,
  input  logic [LED_MODE_W-1:0] mode,
  input  logic                  blink_phase,
  input  logic                  lamp_active,
  output logic                  q_next
);

  logic [TIMER_BITS-1:0] cnt_q, cnt_d;
  logic                  latch_q, latch_d;
  led_mode_t             mode_e;

  assign mode_e = led_mode_t'(mode);

  // OFF leaves the zero defaults in place, wiping both pieces of state.
  always_comb begin
    cnt_d   = '0;
    latch_d = 1'b0;
    q_next  = 1'b0;
    if (mode_e != MODE_OFF) begin
      if (d) begin
        cnt_d = HOLD_V;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - TIMER_BITS'(1);
      end
      latch_d = latch_q;
      if (mode_e == MODE_LATCH) begin
        if (d) begin
          latch_d = 1'b1;
        end else if (clr) begin
          latch_d = 1'b0;
        end
      end
    end
    case (mode_e)
      MODE_STRETCH: q_next = (cnt_d != '0);
      MODE_LATCH:   q_next = latch_d;
      MODE_BLINK:   q_next = (cnt_d != '0) && !blink_phase;
      default:      q_next = 1'b0;
    endcase
    if (lamp_active) begin
      q_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q   <= '0;
      latch_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
    end
  end

endmodule

// File: rtl/led_stretch_bank.sv
// Multi-channel LED pulse stretcher with shared blink prescaler and a
// post-reset lamp test. Outputs are active-high LED-on.
module led_stretch_bank
  import led_pkg::*;
#(
  parameter int CHANNELS   = 8,
  parameter int TIMER_BITS = 15,
  parameter int HOLD       = 2**TIMER_BITS - 1,
  parameter int BLINK_BITS = 12,
  parameter int LAMP_TEST  = 1
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [CHANNELS-1:0]        d,
  input  logic [LED_MODE_W*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]        clr,
  output logic [CHANNELS-1:0]        q
);

  localparam logic [TIMER_BITS-1:0] HOLD_V    = TIMER_BITS'(HOLD);
  localparam logic [TIMER_BITS-1:0] LAMP_INIT = (LAMP_TEST != 0) ? HOLD_V : '0;

  if (HOLD < 1 || longint'(HOLD) >= (64'sd1 <<< TIMER_BITS)) begin : g_bad_hold
    $error("led_stretch_bank: HOLD out of range for TIMER_BITS");
  end
  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("led_stretch_bank: CHANNELS out of range");
  end

  logic [BLINK_BITS-1:0] presc_q, presc_d;
  logic [TIMER_BITS-1:0] lamp_q, lamp_d;
  logic [CHANNELS-1:0]   q_q, q_d;
  logic [MODE_BUS_W-1:0] mode_ext;
  logic                  blink_phase;
  logic                  lamp_active;

  assign mode_ext = MODE_BUS_W'(mode);

  // Lamp activity and blink phase both look at the post-edge values so that
  // the registered q reflects the state the same edge produces.
  always_comb begin
    presc_d = presc_q + BLINK_BITS'(1);
    lamp_d  = '0;
    if (lamp_q != '0) begin
      lamp_d = lamp_q - TIMER_BITS'(1);
    end
    blink_phase = presc_d[BLINK_BITS-1];
    lamp_active = (lamp_d != '0);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    led_stretch_chan #(
      .TIMER_BITS (TIMER_BITS),
      .HOLD_V     (HOLD_V)
    ) u_chan (
      .clk         (clk),
      .nrst        (nrst),
      .d           (d[i]),
      .clr         (clr[i]),
      .mode        (chan_mode(mode_ext, i)),
      .blink_phase (blink_phase),
      .lamp_active (lamp_active),
      .q_next      (q_d[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      presc_q <= '0;
      lamp_q  <= LAMP_INIT;
      q_q     <= '1;
    end else begin
      presc_q <= presc_d;
      lamp_q  <= lamp_d;
      q_q     <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_led_stretch_bank.sv
// Directed bench for led_stretch_bank: two instances (lamp test with short
// hold, and no lamp test with a long hold for blinking), scoreboard checked.
module tb_led_stretch_bank;

  logic       clk = 1'b0;
  logic       nrst_a, nrst_b;
  logic [3:0] d_a, d_b, clr_a, clr_b, q_a, q_b;
  logic [7:0] mode_a, mode_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [3:0] ea;
    logic [3:0] eb;
    bit         ca;
    bit         cb;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  led_stretch_bank #(
    .CHANNELS(4), .TIMER_BITS(5), .HOLD(4), .BLINK_BITS(3), .LAMP_TEST(1)
  ) dut_a (
    .clk(clk), .nrst(nrst_a), .d(d_a), .mode(mode_a), .clr(clr_a), .q(q_a)
  );

  led_stretch_bank #(
    .CHANNELS(4), .TIMER_BITS(5), .HOLD(20), .BLINK_BITS(3), .LAMP_TEST(0)
  ) dut_b (
    .clk(clk), .nrst(nrst_b), .d(d_b), .mode(mode_b), .clr(clr_b), .q(q_b)
  );

  // Push the expectation for the coming edge, then pop and compare after it.
  task automatic step(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                      input bit ca, input bit cb);
    exp_t e;
    e.tag = tag; e.ea = ea; e.eb = eb; e.ca = ca; e.cb = cb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.ca) begin
      checks++;
      assert (q_a === e.ea) else begin
        errors++;
        $error("FAIL %s dut_a q=%h expected %h", e.tag, q_a, e.ea);
      end
    end
    if (e.cb) begin
      checks++;
      assert (q_b === e.eb) else begin
        errors++;
        $error("FAIL %s dut_b q=%h expected %h", e.tag, q_b, e.eb);
      end
    end
  endtask

  initial begin
    logic [3:0] exp_blink;
    nrst_a = 1'b0; nrst_b = 1'b0;
    d_a = '0; d_b = '0; clr_a = '0; clr_b = '0;
    mode_a = 8'h55; mode_b = 8'h55;

    // Reset and lamp test
    repeat (3) step("reset", 4'hF, 4'hF, 1, 1);
    nrst_a = 1'b1; nrst_b = 1'b1;
    repeat (3) step("lamp_on", 4'hF, 4'h0, 1, 1);
    step("lamp_end", 4'h0, 4'h0, 1, 1);
    step("idle", 4'h0, 4'h0, 1, 1);

    // Stretch with retrigger; clr has no effect in STRETCH
    d_a = 4'b0001;
    step("stretch_trig", 4'b0001, 4'h0, 1, 1);
    d_a = 4'b0000; clr_a = 4'b0001;
    step("stretch_hold", 4'b0001, 4'h0, 1, 1);
    d_a = 4'b0001; clr_a = 4'b0000;
    step("stretch_retrig", 4'b0001, 4'h0, 1, 1);
    d_a = 4'b0000;
    repeat (3) step("stretch_hold2", 4'b0001, 4'h0, 1, 1);
    step("stretch_expire", 4'h0, 4'h0, 1, 1);
    step("stretch_idle", 4'h0, 4'h0, 1, 1);

    // Latch on channel 1, d wins over clr
    mode_a = 8'h59;
    step("latch_mode", 4'h0, 4'h0, 1, 1);
    d_a = 4'b0010;
    step("latch_set", 4'b0010, 4'h0, 1, 1);
    d_a = 4'b0000;
    repeat (4) step("latch_hold", 4'b0010, 4'h0, 1, 1);
    d_a = 4'b0010; clr_a = 4'b0010;
    step("latch_d_wins", 4'b0010, 4'h0, 1, 1);
    d_a = 4'b0000; clr_a = 4'b0000;
    repeat (4) step("latch_hold2", 4'b0010, 4'h0, 1, 1);
    clr_a = 4'b0010;
    step("latch_clr", 4'h0, 4'h0, 1, 1);
    clr_a = 4'b0000;
    step("latch_cleared", 4'h0, 4'h0, 1, 1);

    // OFF override on channel 3
    mode_a = 8'h55;
    step("off_setup", 4'h0, 4'h0, 1, 1);
    d_a = 4'b1000;
    step("off_pre_trig", 4'b1000, 4'h0, 1, 1);
    d_a = 4'b0000;
    step("off_pre_hold", 4'b1000, 4'h0, 1, 1);
    mode_a = 8'h15;
    step("off_now", 4'h0, 4'h0, 1, 1);
    d_a = 4'b1000;
    step("off_d_ignored", 4'h0, 4'h0, 1, 1);
    d_a = 4'b0000; mode_a = 8'h55;
    step("off_back", 4'h0, 4'h0, 1, 1);
    step("off_back2", 4'h0, 4'h0, 1, 1);

    // Reset mid-hold restarts the lamp test
    d_a = 4'b0001;
    step("a_pre_reset", 4'b0001, 4'h0, 1, 1);
    d_a = 4'b0000; nrst_a = 1'b0;
    step("a_mid_reset", 4'hF, 4'h0, 1, 1);
    nrst_a = 1'b1;
    repeat (3) step("a_lamp_again", 4'hF, 4'h0, 1, 1);
    step("a_lamp_again_end", 4'h0, 4'h0, 1, 1);

    // Blink on dut_b channel 2: HOLD=20, period 8, prescaler restarted by reset
    nrst_b = 1'b0; mode_b = 8'h75;
    step("b_reset", 4'h0, 4'hF, 0, 1);
    nrst_b = 1'b1; d_b = 4'b0100;
    step("blink_n1", 4'h0, 4'b0100, 0, 1);
    d_b = 4'b0000;
    for (int n = 2; n <= 26; n++) begin
      exp_blink = (n <= 20 && (n % 8) < 4) ? 4'b0100 : 4'b0000;
      step("blink", 4'h0, exp_blink, 0, 1);
    end

    // Reset mid-hold without lamp test clears counters
    mode_b = 8'h55; d_b = 4'b0001;
    step("b_trig", 4'h0, 4'b0001, 0, 1);
    d_b = 4'b0000;
    step("b_hold", 4'h0, 4'b0001, 0, 1);
    nrst_b = 1'b0;
    step("b_mid_reset", 4'h0, 4'hF, 0, 1);
    nrst_b = 1'b1;
    repeat (3) step("b_after_reset", 4'h0, 4'h0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
